// File: rtl/fibo_stream.sv
// Fibonacci-style term generator with a valid/ready output stream, runtime seed load and overflow flag.
// Define FIBO_STREAM_SATURATE_EN to stop at the first carried sum (DONE state, out_last) instead of wrapping.
module fibo_stream #(
  parameter int unsigned    W     = 8,
  parameter int unsigned    IW    = 16,
  parameter logic [W-1:0]   SEED0 = '0,
  parameter logic [W-1:0]   SEED1 = {{(W-1){1'b0}}, 1'b1}
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          hold,
  input  logic          load,
  input  logic [W-1:0]  load_a,
  input  logic [W-1:0]  load_b,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [W-1:0]  out_data,
  output logic [IW-1:0] out_idx,
  output logic          out_last,
  output logic          ovf
);

`ifdef FIBO_STREAM_SATURATE_EN
  typedef enum logic [1:0] {PRIME = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
`else
  typedef enum logic [1:0] {PRIME = 2'd0, RUN = 2'd1} state_t;
`endif

  state_t        state_q, state_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          ovf_q, ovf_d;
  logic [W:0]    sum;
  logic          accept;

  assign sum       = {1'b0, a_q} + {1'b0, b_q};
  assign out_valid = (state_q != PRIME) && !hold;
  assign accept    = out_valid && out_ready;
  assign out_data  = a_q;
  assign out_idx   = idx_q;
  assign ovf       = ovf_q;

`ifdef FIBO_STREAM_SATURATE_EN
  assign out_last = (state_q == DONE);
`else
  assign out_last = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    ovf_d   = ovf_q;
    if (load) begin
      // Load overrides everything, including a beat accepted in this cycle.
      a_d     = load_a;
      b_d     = load_b;
      idx_d   = '0;
      ovf_d   = 1'b0;
      state_d = PRIME;
    end else begin
      case (state_q)
        PRIME: state_d = RUN;
        RUN: begin
          if (accept) begin
            a_d   = b_q;
            idx_d = idx_q + IW'(1);
`ifdef FIBO_STREAM_SATURATE_EN
            if (sum[W]) begin
              // b is kept so the final term stays frozen in a.
              ovf_d   = 1'b1;
              state_d = DONE;
            end else begin
              b_d = sum[W-1:0];
            end
`else
            b_d   = sum[W-1:0];
            ovf_d = ovf_q | sum[W];
`endif
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= PRIME;
      a_q     <= SEED0;
      b_q     <= SEED1;
      idx_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_fibo_stream.sv
// Directed self-checking bench for fibo_stream (W=8, seeds 0/1): sequence, hold, backpressure,
// load over an accepted beat, asynchronous mid-stream reset.
module tb_fibo_stream;
  logic        clk = 1'b0;
  logic        rst;
  logic        hold;
  logic        load;
  logic [7:0]  load_a;
  logic [7:0]  load_b;
  logic        out_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [15:0] out_idx;
  logic        out_last;
  logic        ovf;

  int n_compared   = 0;
  int n_mismatched = 0;

  logic [7:0] fib_tbl [0:14];
  logic [7:0] luc_tbl [0:9];

  fibo_stream #(.W(8), .IW(16)) dut (
    .clk(clk), .rst(rst), .hold(hold), .load(load),
    .load_a(load_a), .load_b(load_b), .out_ready(out_ready),
    .out_valid(out_valid), .out_data(out_data), .out_idx(out_idx),
    .out_last(out_last), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_beat(input string tag, input logic v, input logic [7:0] d,
                            input logic [15:0] i, input logic o, input logic l);
    check({tag, ".valid"}, 32'(out_valid), 32'(v));
    check({tag, ".data"},  32'(out_data),  32'(d));
    check({tag, ".idx"},   32'(out_idx),   32'(i));
    check({tag, ".ovf"},   32'(ovf),       32'(o));
    check({tag, ".last"},  32'(out_last),  32'(l));
    $display("%0t %s: valid=%0d data=%0d idx=%0d ovf=%0d last=%0d",
             $time, tag, out_valid, out_data, out_idx, ovf, out_last);
  endtask

  initial begin
    fib_tbl = '{8'd0, 8'd1, 8'd1, 8'd2, 8'd3, 8'd5, 8'd8, 8'd13, 8'd21, 8'd34,
                8'd55, 8'd89, 8'd144, 8'd233, 8'd121};
    luc_tbl = '{8'd2, 8'd1, 8'd3, 8'd4, 8'd7, 8'd11, 8'd18, 8'd29, 8'd47, 8'd76};
    rst = 1'b1; hold = 1'b0; load = 1'b0; load_a = '0; load_b = '0; out_ready = 1'b1;

    repeat (2) @(negedge clk);
    #1 check_beat("reset", 1'b0, 8'd0, 16'd0, 1'b0, 1'b0);
    rst = 1'b0;
    #1 check_beat("prime", 1'b0, 8'd0, 16'd0, 1'b0, 1'b0);

    for (int k = 0; k <= 4; k++) begin
      @(negedge clk); #1 check_beat("fib", 1'b1, fib_tbl[k], 16'(k), 1'b0, 1'b0);
    end

    hold = 1'b1;
    for (int h = 0; h < 3; h++) begin
      #1 check_beat("hold", 1'b0, 8'd3, 16'd4, 1'b0, 1'b0);
      if (h < 2) begin
        @(negedge clk); #1;
      end
    end
    @(negedge clk);
    hold = 1'b0;
    #1 check_beat("unhold", 1'b1, 8'd3, 16'd4, 1'b0, 1'b0);

    for (int k = 5; k <= 7; k++) begin
      @(negedge clk); #1 check_beat("fib", 1'b1, fib_tbl[k], 16'(k), 1'b0, 1'b0);
    end

    out_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      #1 check_beat("stall", 1'b1, 8'd13, 16'd7, 1'b0, 1'b0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1 check_beat("unstall", 1'b1, 8'd13, 16'd7, 1'b0, 1'b0);

    for (int k = 8; k <= 14; k++) begin
      @(negedge clk);
`ifdef FIBO_STREAM_SATURATE_EN
      if (k >= 13) begin
        #1 check_beat("sat", 1'b1, 8'd233, 16'd13, 1'b1, 1'b1);
      end else begin
        #1 check_beat("fib", 1'b1, fib_tbl[k], 16'(k), 1'b0, 1'b0);
      end
`else
      #1 check_beat("fib", 1'b1, fib_tbl[k], 16'(k), k >= 13, 1'b0);
`endif
    end

    load = 1'b1; load_a = 8'd2; load_b = 8'd1;
    @(negedge clk);
    load = 1'b0;
    #1 check_beat("load_prime", 1'b0, 8'd2, 16'd0, 1'b0, 1'b0);

    for (int k = 0; k <= 9; k++) begin
      @(negedge clk); #1 check_beat("lucas", 1'b1, luc_tbl[k], 16'(k), 1'b0, 1'b0);
    end

    #2 rst = 1'b1;
    #1 check_beat("async_rst", 1'b0, 8'd0, 16'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1 check_beat("rst_prime", 1'b0, 8'd0, 16'd0, 1'b0, 1'b0);
    for (int k = 0; k <= 3; k++) begin
      @(negedge clk); #1 check_beat("restart", 1'b1, fib_tbl[k], 16'(k), 1'b0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
